shift_seq_unit: RTL and testbench
=================================

# shift_seq_unit

Multicycle shift/rotate execution unit for the multicycle processor datapath. It accepts a data word, an operation code and a shift amount, then applies the single-position shift operation repeatedly, one position per clock. It reports completion through a start/busy/done handshake and produces result, carry and zero flags. The single-cycle 1-bit shifter covers one-position shifts; this block covers N-position shifts without a barrel shifter.

## Interface
Parameters:
- WIDTH, 8, data word width
- AMT_W, 3, shift-amount width (amounts 0..2^AMT_W-1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  3  operation: 000 ROL, 001 ROR, 010 SLL, 011 SRA, 100 SRL, 101-111 NOP
- amount  in  AMT_W  number of positions
- data_in  in  WIDTH  operand, treated as signed for SRA
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  shifted word; held until next accepted start
- carry  out  1  last bit shifted or rotated out
- zero  out  1  result == 0

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch data_in into the working register, latch op, and set count = amount.
  - If amount == 0 or op is NOP, go to DONE; otherwise go to RUN.
- RUN: each clock applies one step to the working register, updates carry, and decrements count. The step that takes count from 1 to 0 also transitions to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Step definitions:
  - ROL: {w[W-2:0],w[W-1]}, carry=w[W-1]
  - ROR: {w[0],w[W-1:1]}, carry=w[0]
  - SLL: w<<1, carry=w[W-1]
  - SRA: sign-replicating >>1, carry=w[0]
  - SRL: w>>1 zero-filled, carry=w[0]
- carry is cleared on start. It stays 0 for amount 0 and for NOP.
- NOP returns data_in unchanged with carry=0.
- result is the working register; zero is derived from it combinationally. Neither changes outside RUN and start acceptance.
- start while busy (including the DONE cycle) is ignored and has no side effects.
- op and amount are latched at acceptance. Input changes during RUN have no effect.
- amount ≥ WIDTH is legal:
  - rotates wrap naturally
  - SLL/SRL saturate to 0
  - SRA saturates to all sign bits

## Timing
- Reset asserted, at any time including mid-RUN:
  - state=IDLE, busy=0, done=0, result=0, carry=0, zero=1, count=0
  - the operation is aborted with no done pulse
- Call the cycle in which start is sampled high in IDLE "cycle 0".
- busy rises in cycle 1.
- done is high in cycle N+1 for amount N ≥ 1, and in cycle 1 for amount 0 or NOP.
- busy falls in the cycle after done, when IDLE is re-entered. The earliest next accepted start is that cycle.
- result, carry and zero are final and valid in the done cycle and remain stable until the next accepted start.

## Structure
- Package shift_pkg holds:
  - op-code localparams (OP_ROL=3'b000, OP_ROR=3'b001, OP_SLL=3'b010, OP_SRA=3'b011, OP_SRL=3'b100)
  - the FSM state encoding (IDLE, RUN, DONE)
- Sub-module shift_step performs the combinational one-position step: inputs op and w, outputs w_next and bit_out. It is instantiated once inside shift_seq_unit.
- The top level contains the FSM, count register, working register and carry register.

## Test plan
- ROL, data 0x81, amount 3 -> result 0x0C, carry 0, zero 0, done high in cycle 4, busy high cycles 1-4.
- SRL, data 0x05, amount 3 -> result 0x00, carry 1, zero 1, done in cycle 4.
- SRA, data 0x90, amount 2 -> result 0xE4, carry 0. Then SLL, data 0xFF, amount 7 -> result 0x80, carry 1, done in cycle 8.
- ROR, data 0x5A, amount 0 -> result 0x5A, carry 0, done in cycle 1. Then op 3'b110, data 0x33, amount 5 -> result 0x33, carry 0, done in cycle 1.
- Start SLL 0x01 amount 7, then pulse start with different operands in cycles 3 and 8 (done cycle) -> both ignored, result 0x80, a single done pulse.
- Start ROR 0xF0 amount 6, assert rst in cycle 3 -> outputs go immediately to reset values, no done. After release, start SRL 0x80 amount 1 -> result 0x40, done in cycle 2.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the multicycle shift/rotate unit.
// Holds the operation encodings, the FSM state type and a small decode helper.
package shift_pkg;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Codes 101..111 are reserved and behave as NOP.
  function automatic logic is_nop(input logic [2:0] op);
    return op > OP_SRL;
  endfunction

endpackage

// File: rtl/shift_seq_unit_if.sv
// Request/response bundle of the shift/rotate unit.
//   master: drives start, op, amount, data_in; observes busy, done, result, carry, zero
//   slave : the execution unit side
interface shift_seq_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) ();
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  modport master (
    output start, op, amount, data_in,
    input  busy, done, result, carry, zero
  );

  modport slave (
    input  start, op, amount, data_in,
    output busy, done, result, carry, zero
  );
endinterface

// File: rtl/shift_step.sv
// Combinational one-position shift/rotate step.
//   op      : operation code (NOP codes pass w through, bit_out = 0)
//   w       : current working word
//   w_next  : word after one step
//   bit_out : bit rotated or shifted out by this step
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] w_next,
  output logic             bit_out
);

  always_comb begin
    w_next  = w;
    bit_out = 1'b0;
    case (op)
      OP_ROL: begin
        w_next  = {w[WIDTH-2:0], w[WIDTH-1]};
        bit_out = w[WIDTH-1];
      end
      OP_ROR: begin
        w_next  = {w[0], w[WIDTH-1:1]};
        bit_out = w[0];
      end
      OP_SLL: begin
        w_next  = {w[WIDTH-2:0], 1'b0};
        bit_out = w[WIDTH-1];
      end
      OP_SRA: begin
        w_next  = {w[WIDTH-1], w[WIDTH-1:1]};
        bit_out = w[0];
      end
      OP_SRL: begin
        w_next  = {1'b0, w[WIDTH-1:1]};
        bit_out = w[0];
      end
      default: begin
        w_next  = w;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multicycle shift/rotate execution unit: applies one single-position step per clock
// until the latched amount is exhausted.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : slave side of shift_seq_unit_if
//         start/op/amount/data_in in; busy/done/result/carry/zero out
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  shift_seq_unit_if.slave  bus
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] w_q, w_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] w_next;
  logic             bit_out;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op      (op_q),
    .w       (w_q),
    .w_next  (w_next),
    .bit_out (bit_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.amount == '0 || is_nop(bus.op)) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // The step that moves count from 1 to 0 is the last one.
        if (count_q == AMT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.busy = (state_q != StIdle);
    bus.done = (state_q == StDone);
  end

  // Datapath next-state: registers only move on acceptance or during RUN.
  always_comb begin
    w_d     = w_q;
    op_d    = op_q;
    count_d = count_q;
    carry_d = carry_q;
    if (state_q == StIdle && bus.start) begin
      w_d     = bus.data_in;
      op_d    = bus.op;
      count_d = bus.amount;
      carry_d = 1'b0;
    end else if (state_q == StRun) begin
      w_d     = w_next;
      carry_d = bit_out;
      count_d = count_q - AMT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q     <= '0;
      op_q    <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      w_q     <= w_d;
      op_q    <= op_d;
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign bus.result = w_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = (w_q == '0);

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: table of directed operations plus
// hand-written sequences for ignored starts and mid-operation reset.
module tb_shift_seq_unit;

  logic clk;
  logic rst;

  shift_seq_unit_if #(.WIDTH(8), .AMT_W(3)) bus ();

  shift_seq_unit #(
    .WIDTH (8),
    .AMT_W (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [2:0] amt;
    logic [7:0] data;
    logic [7:0] exp_res;
    logic       exp_carry;
    int         exp_done;
  } vec_t;

  vec_t vecs[11];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a request at the falling edge; returns at #1 into cycle 1.
  task automatic accept(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] data);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.amount  = amt;
    bus.data_in = data;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    // Scramble operands: must not affect the running operation.
    bus.op      = 3'b010;
    bus.amount  = 3'd1;
    bus.data_in = 8'h3C;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   done_cyc;
    int   ndone;
    logic busy_ok;
    logic post_seen;
    done_cyc  = 0;
    ndone     = 0;
    busy_ok   = 1'b1;
    post_seen = 1'b0;
    accept(v.op, v.amt, v.data);
    for (int c = 1; c <= 40; c++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (done_cyc == 0) begin
          done_cyc = c;
          check($sformatf("v%0d result", idx), 32'(bus.result), 32'(v.exp_res));
          check($sformatf("v%0d carry", idx), 32'(bus.carry), 32'(v.exp_carry));
          check($sformatf("v%0d zero", idx), 32'(bus.zero), 32'(v.exp_res == 8'h00));
        end
      end
      if (done_cyc == 0 || c == done_cyc) begin
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
      end else begin
        post_seen = 1'b1;
        check($sformatf("v%0d busy after done", idx), 32'(bus.busy), 32'd0);
        check($sformatf("v%0d result held", idx), 32'(bus.result), 32'(v.exp_res));
        break;
      end
      @(posedge clk);
      #1;
    end
    check($sformatf("v%0d done cycle", idx), 32'(done_cyc), 32'(v.exp_done));
    check($sformatf("v%0d done count", idx), 32'(ndone), 32'd1);
    check($sformatf("v%0d busy profile", idx), 32'(busy_ok), 32'd1);
    check($sformatf("v%0d idle reached", idx), 32'(post_seen), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 3'd3, 8'h81, 8'h0C, 1'b0, 4};
    vecs[1]  = '{3'b100, 3'd3, 8'h05, 8'h00, 1'b1, 4};
    vecs[2]  = '{3'b011, 3'd2, 8'h90, 8'hE4, 1'b0, 3};
    vecs[3]  = '{3'b010, 3'd7, 8'hFF, 8'h80, 1'b1, 8};
    vecs[4]  = '{3'b001, 3'd0, 8'h5A, 8'h5A, 1'b0, 1};
    vecs[5]  = '{3'b110, 3'd5, 8'h33, 8'h33, 1'b0, 1};
    vecs[6]  = '{3'b011, 3'd7, 8'h80, 8'hFF, 1'b0, 8};
    vecs[7]  = '{3'b001, 3'd7, 8'h01, 8'h02, 1'b0, 8};
    vecs[8]  = '{3'b100, 3'd7, 8'hFF, 8'h01, 1'b1, 8};
    vecs[9]  = '{3'b000, 3'd4, 8'hA5, 8'h5A, 1'b0, 5};
    vecs[10] = '{3'b111, 3'd3, 8'h00, 8'h00, 1'b0, 1};

    bus.start   = 1'b0;
    bus.op      = 3'b000;
    bus.amount  = 3'd0;
    bus.data_in = 8'h00;
    rst = 1'b1;
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset carry", 32'(bus.carry), 32'd0);
    check("reset zero", 32'(bus.zero), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_vec(i, vecs[i]);
    end

    // Starts while busy (cycle 3 and the done cycle) must be ignored.
    begin
      int ndone;
      int done_cyc;
      ndone    = 0;
      done_cyc = 0;
      accept(3'b010, 3'd7, 8'h01);
      for (int c = 1; c <= 12; c++) begin
        if (bus.done === 1'b1) begin
          ndone++;
          if (done_cyc == 0) done_cyc = c;
        end
        if (c == 9) check("ign busy after done", 32'(bus.busy), 32'd0);
        if (c == 3 || c == 8) begin
          bus.start   = 1'b1;
          bus.op      = 3'b100;
          bus.amount  = 3'd1;
          bus.data_in = 8'hFF;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
      check("ign done count", 32'(ndone), 32'd1);
      check("ign done cycle", 32'(done_cyc), 32'd8);
      check("ign result", 32'(bus.result), 32'h80);
      check("ign carry", 32'(bus.carry), 32'd0);
      check("ign busy final", 32'(bus.busy), 32'd0);
    end

    // Reset in the middle of a run aborts it with no done pulse.
    begin
      int ndone;
      ndone = 0;
      accept(3'b001, 3'd6, 8'hF0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("abort busy before rst", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort result", 32'(bus.result), 32'd0);
      check("abort carry", 32'(bus.carry), 32'd0);
      check("abort zero", 32'(bus.zero), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk);
        #1;
        if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
      end
      check("abort quiet after rst", 32'(ndone), 32'd0);
      run_vec(11, '{3'b100, 3'd1, 8'h80, 8'h40, 1'b0, 2});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
